// File: rtl/fpu_wb_arbiter.sv
// fpu_wb_arbiter: per-requester result FIFOs drained by a dual-grant round-robin onto two RF write ports.
// Optional macro FPU_WB_PERF_EN adds saturating stall/defer performance counters.
module fpu_wb_arbiter #(
  parameter int NREQ  = 14,
  parameter int DEPTH = 4,
  parameter int SLACK = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rt,
  input  logic [32*NREQ-1:0]   req_data,
  output logic                 u_wb_valid,
  output logic [4:0]           u_wb_rt,
  output logic [31:0]          u_wb_data,
  output logic                 l_wb_valid,
  output logic [4:0]           l_wb_rt,
  output logic [31:0]          l_wb_data,
  output logic                 stall_req,
  output logic                 overflow
`ifdef FPU_WB_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_defer_cnt
`endif
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_C = CNT_W'(DEPTH - SLACK);
  localparam logic [IDX_W:0]   NREQ_C  = (IDX_W+1)'(NREQ);

  logic [4:0]       mem_rt   [NREQ][DEPTH];
  logic [31:0]      mem_data [NREQ][DEPTH];
  logic [PTR_W-1:0] wr_ptr   [NREQ];
  logic [PTR_W-1:0] rd_ptr   [NREQ];
  logic [CNT_W-1:0] cnt      [NREQ];
  logic [CNT_W-1:0] cnt_nxt  [NREQ];
  logic [4:0]       head_rt  [NREQ];
  logic [31:0]      head_data[NREQ];
  logic [NREQ-1:0]  pop, push_ok, push_drop;
  logic [IDX_W-1:0] rr_ptr, rr_nxt, last_idx;
  logic [IDX_W:0]   scan_sum, rr_sum;
  logic [IDX_W-1:0] scan_idx;
  logic             stall_nxt;

  logic             g0_vld_p0, g1_vld_p0, defer_p0;
  logic [IDX_W-1:0] g0_idx_p0, g1_idx_p0;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      head_rt[i]   = mem_rt[i][rd_ptr[i]];
      head_data[i] = mem_data[i][rd_ptr[i]];
    end
  end

  // ---- p0: combinational arbitration over FIFO heads ----
  always_comb begin
    g0_vld_p0 = 1'b0;
    g1_vld_p0 = 1'b0;
    g0_idx_p0 = '0;
    g1_idx_p0 = '0;
    defer_p0  = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan_sum >= NREQ_C) scan_sum = scan_sum - NREQ_C;
      scan_idx = scan_sum[IDX_W-1:0];
      if (cnt[scan_idx] != '0) begin
        if (!g0_vld_p0) begin
          g0_vld_p0 = 1'b1;
          g0_idx_p0 = scan_idx;
        end else if (!g1_vld_p0) begin
          // Two writes to one register in a cycle would race; defer the later one.
          if (head_rt[scan_idx] == head_rt[g0_idx_p0]) defer_p0 = 1'b1;
          else begin
            g1_vld_p0 = 1'b1;
            g1_idx_p0 = scan_idx;
          end
        end
      end
    end
  end

  always_comb begin
    stall_nxt = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pop[i]       = (g0_vld_p0 && g0_idx_p0 == IDX_W'(i)) ||
                     (g1_vld_p0 && g1_idx_p0 == IDX_W'(i));
      push_ok[i]   = req_valid[i] && ((cnt[i] != FULL_C) || pop[i]);
      push_drop[i] = req_valid[i] && (cnt[i] == FULL_C) && !pop[i];
      cnt_nxt[i]   = cnt[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
      if (cnt_nxt[i] >= STALL_C) stall_nxt = 1'b1;
    end
  end

  always_comb begin
    last_idx = g1_vld_p0 ? g1_idx_p0 : g0_idx_p0;
    rr_sum   = {1'b0, last_idx} + (IDX_W+1)'(1);
    if (!g0_vld_p0)          rr_nxt = rr_ptr;
    else if (rr_sum == NREQ_C) rr_nxt = '0;
    else                     rr_nxt = rr_sum[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (push_ok[i]) begin
        mem_rt[i][wr_ptr[i]]   <= req_rt[5*i +: 5];
        mem_data[i][wr_ptr[i]] <= req_data[32*i +: 32];
      end
    end
  end

  // ---- p1: FIFO state, round-robin pointer and registered write ports ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr     <= '0;
      stall_req  <= 1'b0;
      overflow   <= 1'b0;
      u_wb_valid <= 1'b0;
      u_wb_rt    <= '0;
      u_wb_data  <= '0;
      l_wb_valid <= 1'b0;
      l_wb_rt    <= '0;
      l_wb_data  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
      end
      rr_ptr    <= rr_nxt;
      stall_req <= stall_nxt;
      if (|push_drop) overflow <= 1'b1;
      u_wb_valid <= g0_vld_p0;
      if (g0_vld_p0) begin
        u_wb_rt   <= head_rt[g0_idx_p0];
        u_wb_data <= head_data[g0_idx_p0];
      end
      l_wb_valid <= g1_vld_p0;
      if (g1_vld_p0) begin
        l_wb_rt   <= head_rt[g1_idx_p0];
        l_wb_data <= head_data[g1_idx_p0];
      end
    end
  end

`ifdef FPU_WB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_stall_cnt <= '0;
      perf_defer_cnt <= '0;
    end else begin
      if (stall_req && perf_stall_cnt != 32'hFFFF_FFFF) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (defer_p0 && perf_defer_cnt != 32'hFFFF_FFFF) perf_defer_cnt <= perf_defer_cnt + 32'd1;
    end
  end
`else
  logic perf_unused;
  assign perf_unused = defer_p0;
`endif

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Directed, table-driven bench for fpu_wb_arbiter with hand-written multi-cycle sequences.
module tb_fpu_wb_arbiter;
  localparam int NREQ = 14;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [5*NREQ-1:0]   req_rt = '0;
  logic [32*NREQ-1:0]  req_data = '0;
  logic                u_wb_valid, l_wb_valid, stall_req, overflow;
  logic [4:0]          u_wb_rt, l_wb_rt;
  logic [31:0]         u_wb_data, l_wb_data;
`ifdef FPU_WB_PERF_EN
  logic [31:0]         perf_stall_cnt, perf_defer_cnt;
`endif

  fpu_wb_arbiter dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_rt(req_rt), .req_data(req_data),
    .u_wb_valid(u_wb_valid), .u_wb_rt(u_wb_rt), .u_wb_data(u_wb_data),
    .l_wb_valid(l_wb_valid), .l_wb_rt(l_wb_rt), .l_wb_data(l_wb_data),
    .stall_req(stall_req), .overflow(overflow)
`ifdef FPU_WB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_defer_cnt(perf_defer_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_rt    = '0;
    req_data  = '0;
  endtask

  task automatic set_req(input int i, input logic [4:0] rt, input logic [31:0] d);
    req_valid[i]        = 1'b1;
    req_rt[5*i +: 5]    = rt;
    req_data[32*i +: 32] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    bit          keep;
    int          a;
    int          b;
    logic [4:0]  rt_a, rt_b;
    logic [31:0] d_a, d_b;
    logic        u_v;  logic [4:0] u_rt;  logic [31:0] u_d;
    logic        l_v;  logic [4:0] l_rt;  logic [31:0] l_d;
    logic        u2_v; logic [4:0] u2_rt; logic [31:0] u2_d;
  } vec_t;

  vec_t vecs[6];

  bit mon_en = 1'b0;
  int mon_cnt = 0;
  int drop_seen = 0;

  function automatic bit is_dropped(input logic [31:0] d);
    return (d[31:16] == 16'hA005) && (d[15:0] >= 16'd8);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (u_wb_valid) begin
        mon_cnt++;
        if (is_dropped(u_wb_data)) drop_seen++;
      end
      if (l_wb_valid) begin
        mon_cnt++;
        if (is_dropped(l_wb_data)) drop_seen++;
      end
    end
  end

  int emitted;

  initial begin
    vecs[0] = '{1'b0, 4, -1, 5'd7, 5'd0, 32'h3F80_0000, 32'h0,
                1'b1, 5'd7, 32'h3F80_0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0};
    vecs[1] = '{1'b0, 0, 5, 5'd3, 5'd9, 32'h1111_1111, 32'h2222_2222,
                1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd9, 32'h2222_2222, 1'b0, 5'd0, 32'h0};
    // rr_ptr is 6 after the previous vector, so requester 7 wins over 3
    vecs[2] = '{1'b1, 3, 7, 5'd1, 5'd2, 32'h3333_3333, 32'h7777_7777,
                1'b1, 5'd2, 32'h7777_7777, 1'b1, 5'd1, 32'h3333_3333, 1'b0, 5'd0, 32'h0};
    vecs[3] = '{1'b0, 2, 3, 5'd12, 5'd12, 32'hAAAA_0002, 32'hBBBB_0003,
                1'b1, 5'd12, 32'hAAAA_0002, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hBBBB_0003};
    vecs[4] = '{1'b0, 13, 1, 5'd0, 5'd31, 32'hDEAD_BEEF, 32'hCAFE_F00D,
                1'b1, 5'd31, 32'hCAFE_F00D, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0};
    vecs[5] = '{1'b0, 7, 6, 5'd5, 5'd5, 32'h1234_5678, 32'h8765_4321,
                1'b1, 5'd5, 32'h8765_4321, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234_5678};

    do_reset();
    check("rst u_valid", u_wb_valid, 0);
    check("rst l_valid", l_wb_valid, 0);
    check("rst u_rt", u_wb_rt, 0);
    check("rst u_data", u_wb_data, 0);
    check("rst l_rt", l_wb_rt, 0);
    check("rst l_data", l_wb_data, 0);
    check("rst stall", stall_req, 0);
    check("rst overflow", overflow, 0);

    for (int v = 0; v < 6; v++) begin
      if (!vecs[v].keep) do_reset();
      @(negedge clk);
      set_req(vecs[v].a, vecs[v].rt_a, vecs[v].d_a);
      if (vecs[v].b >= 0) set_req(vecs[v].b, vecs[v].rt_b, vecs[v].d_b);
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      check($sformatf("v%0d u_valid", v), u_wb_valid, vecs[v].u_v);
      if (vecs[v].u_v) begin
        check($sformatf("v%0d u_rt", v), u_wb_rt, vecs[v].u_rt);
        check($sformatf("v%0d u_data", v), u_wb_data, vecs[v].u_d);
      end
      check($sformatf("v%0d l_valid", v), l_wb_valid, vecs[v].l_v);
      if (vecs[v].l_v) begin
        check($sformatf("v%0d l_rt", v), l_wb_rt, vecs[v].l_rt);
        check($sformatf("v%0d l_data", v), l_wb_data, vecs[v].l_d);
      end
      @(negedge clk);
      check($sformatf("v%0d u2_valid", v), u_wb_valid, vecs[v].u2_v);
      check($sformatf("v%0d l2_valid", v), l_wb_valid, 0);
      if (vecs[v].u2_v) begin
        check($sformatf("v%0d u2_rt", v), u_wb_rt, vecs[v].u2_rt);
        check($sformatf("v%0d u2_data", v), u_wb_data, vecs[v].u2_d);
      end
    end

`ifdef FPU_WB_PERF_EN
    do_reset();
    @(negedge clk);
    set_req(2, 5'd12, 32'h1);
    set_req(3, 5'd12, 32'h2);
    @(negedge clk);
    clear_inputs();
    repeat (3) @(negedge clk);
    check("perf_defer_cnt", perf_defer_cnt, 1);
    check("perf_stall_cnt", perf_stall_cnt, 0);
`endif

    // Fairness: one entry in every FIFO drains in index order, two per cycle
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
    @(negedge clk);
    clear_inputs();
    for (int k = 0; k < NREQ / 2; k++) begin
      @(negedge clk);
      check($sformatf("fair%0d u_valid", k), u_wb_valid, 1);
      check($sformatf("fair%0d u_rt", k), u_wb_rt, 32'(2*k + 1));
      check($sformatf("fair%0d u_data", k), u_wb_data, 32'h100 + 32'(2*k));
      check($sformatf("fair%0d l_valid", k), l_wb_valid, 1);
      check($sformatf("fair%0d l_rt", k), l_wb_rt, 32'(2*k + 2));
      check($sformatf("fair%0d l_data", k), l_wb_data, 32'h100 + 32'(2*k + 1));
    end
    @(negedge clk);
    check("fair end u_valid", u_wb_valid, 0);
    check("fair end l_valid", l_wb_valid, 0);

    // Stall/overflow: all requesters push for 5 edges, rt = index, data tagged by edge
    do_reset();
    mon_cnt = 0;
    drop_seen = 0;
    mon_en = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      if (e == 2) begin
        check("burst e1 stall", stall_req, 0);
        check("burst e1 overflow", overflow, 0);
      end
      if (e == 3) check("burst e2 stall", stall_req, 1);
      if (e == 5) check("burst e4 overflow", overflow, 0);
      for (int i = 0; i < NREQ; i++) set_req(i, 5'(i), {16'hA000 + 16'(e), 16'(i)});
    end
    @(negedge clk);
    clear_inputs();
    check("burst e5 overflow", overflow, 1);
    repeat (40) @(negedge clk);
    mon_en = 1'b0;
    check("burst drained count", mon_cnt, 64);
    check("burst dropped emitted", drop_seen, 0);
    check("burst stall released", stall_req, 0);
    check("burst overflow sticky", overflow, 1);

    // Reset mid-operation with three buffered entries
    @(negedge clk);
    set_req(0, 5'd10, 32'h5000_0000);
    set_req(1, 5'd10, 32'h5000_0001);
    set_req(2, 5'd10, 32'h5000_0002);
    @(negedge clk);
    clear_inputs();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("midrst u_valid", u_wb_valid, 0);
    check("midrst l_valid", l_wb_valid, 0);
    check("midrst stall", stall_req, 0);
    check("midrst overflow", overflow, 0);
    check("midrst u_data", u_wb_data, 0);
    emitted = 0;
    repeat (5) begin
      @(negedge clk);
      if (u_wb_valid || l_wb_valid) emitted++;
    end
    check("midrst no emission", emitted, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
